// File: rtl/pwm_cmd_sched.sv
// pwm_cmd_sched
//  Command scheduler in front of the PWM drive block. Two command sources
//  (manual remote link, autonomous navigation) compete for a single 16-bit
//  {direction, speed} valid/rdy channel into the PWM command capture.
//  Manual always wins. A manual accept locks autonomous commands out for
//  MAN_HOLD cycles. Every PWM transfer is followed by MIN_GAP idle cycles.
//  A watchdog issues a single neutral command once no external command has
//  been accepted for WDOG_CYCLES cycles.
//  The scheduler shares its clock with the PWM block's command capture, so the
//  output handshake needs no synchronisation.

// Protocol checker for the scheduler ports. It contains only assertions.
module pwm_cmd_sched_chk (
    input logic        clk,
    input logic        rst,
    input logic        man_valid,
    input logic        man_rdy,
    input logic        auto_rdy,
    input logic [15:0] pwm_data,
    input logic        pwm_valid,
    input logic        pwm_rdy
);

    // An offered PWM command stays valid and unchanged until it is taken.
    a_pwm_hold: assert property (@(posedge clk) disable iff (rst)
        (pwm_valid && !pwm_rdy) |=> (pwm_valid && $stable(pwm_data)));

    // Manual has priority, so auto is never offered while manual is requesting.
    a_auto_yields: assert property (@(posedge clk) disable iff (rst)
        auto_rdy |-> !man_valid);

    // Nothing is accepted while an output command is still outstanding.
    a_no_accept_busy: assert property (@(posedge clk) disable iff (rst)
        pwm_valid |-> (!man_rdy && !auto_rdy));

endmodule

module pwm_cmd_sched #(
    parameter logic [15:0] NEUTRAL_CMD = 16'h8000,
    parameter int unsigned MAN_HOLD    = 2000,
    parameter int unsigned MIN_GAP     = 4,
    parameter int unsigned WDOG_CYCLES = 40000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] man_cmd,
    input  logic        man_valid,
    output logic        man_rdy,
    input  logic [15:0] auto_cmd,
    input  logic        auto_valid,
    output logic        auto_rdy,
    output logic [15:0] pwm_data,
    output logic        pwm_valid,
    input  logic        pwm_rdy,
    output logic [1:0]  active_src,
    output logic        timeout_flag
);

    // Counter widths. A zero-valued parameter still gets a 1-bit counter,
    // which simply never leaves zero.
    localparam int HOLD_W = (MAN_HOLD > 0) ? $clog2(MAN_HOLD + 1) : 1;
    localparam int GAP_W  = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MAN_HOLD);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = (MIN_GAP > 0) ? GAP_W'(MIN_GAP - 1) : GAP_W'(0);
    localparam logic [WDOG_W-1:0] WDOG_LOAD = WDOG_W'(WDOG_CYCLES);

    // Source codes reported on active_src.
    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_MAN  = 2'd1;
    localparam logic [1:0] SRC_AUTO = 2'd2;
    localparam logic [1:0] SRC_FAIL = 2'd3;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_ISSUE = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    // Where a completed transfer leads. With no spacing the gap state is skipped.
    localparam state_t POST_XFER = (MIN_GAP == 0) ? S_IDLE : S_GAP;

    state_t             state_r,      state_s;
    logic               pwm_valid_r,  pwm_valid_s;
    logic [15:0]        pwm_data_r,   pwm_data_s;
    logic [1:0]         active_src_r, active_src_s;
    logic               timeout_r,    timeout_s;
    logic [HOLD_W-1:0]  hold_r,       hold_s;
    logic [GAP_W-1:0]   gap_r,        gap_s;
    logic [WDOG_W-1:0]  wdog_r,       wdog_s;
    logic               man_rdy_s;
    logic               auto_rdy_s;
    logic               hold_zero_s;
    logic               wdog_zero_s;

    // Lockout and watchdog expiry conditions.
    always_comb begin
        hold_zero_s = (hold_r == '0);
        wdog_zero_s = (wdog_r == '0);
    end

    // Next state, next register values and the accept strobes.
    always_comb begin
        state_s      = state_r;
        pwm_valid_s  = pwm_valid_r;
        pwm_data_s   = pwm_data_r;
        active_src_s = active_src_r;
        timeout_s    = timeout_r;
        gap_s        = gap_r;
        man_rdy_s    = 1'b0;
        auto_rdy_s   = 1'b0;

        // Lockout and watchdog counters run in every state and stop at zero.
        if (hold_zero_s) begin
            hold_s = hold_r;
        end else begin
            hold_s = hold_r - HOLD_W'(1);
        end
        if (wdog_zero_s) begin
            wdog_s = wdog_r;
        end else begin
            wdog_s = wdog_r - WDOG_W'(1);
        end

        case (state_r)
            S_INIT: begin
                // Startup neutral: raise valid one cycle after reset, hold until taken.
                pwm_data_s   = NEUTRAL_CMD;
                active_src_s = SRC_NONE;
                if (!pwm_valid_r) begin
                    pwm_valid_s = 1'b1;
                end else if (pwm_rdy) begin
                    pwm_valid_s = 1'b0;
                    gap_s       = GAP_LOAD;
                    state_s     = POST_XFER;
                end else begin
                    pwm_valid_s = 1'b1;
                end
            end

            S_IDLE: begin
                man_rdy_s   = 1'b1;
                auto_rdy_s  = !man_valid && hold_zero_s;
                pwm_valid_s = 1'b0;
                if (man_valid) begin
                    pwm_data_s   = man_cmd;
                    pwm_valid_s  = 1'b1;
                    active_src_s = SRC_MAN;
                    timeout_s    = 1'b0;
                    wdog_s       = WDOG_LOAD;
                    hold_s       = HOLD_LOAD;
                    state_s      = S_ISSUE;
                end else if (auto_valid && hold_zero_s) begin
                    pwm_data_s   = auto_cmd;
                    pwm_valid_s  = 1'b1;
                    active_src_s = SRC_AUTO;
                    timeout_s    = 1'b0;
                    wdog_s       = WDOG_LOAD;
                    state_s      = S_ISSUE;
                end else if (wdog_zero_s && !timeout_r) begin
                    // Silence: one neutral per silence period; the flag blocks repeats.
                    pwm_data_s   = NEUTRAL_CMD;
                    pwm_valid_s  = 1'b1;
                    active_src_s = SRC_FAIL;
                    timeout_s    = 1'b1;
                    state_s      = S_ISSUE;
                end else begin
                    state_s = S_IDLE;
                end
            end

            S_ISSUE: begin
                // Wait as long as it takes for the PWM block to take the word.
                if (pwm_rdy) begin
                    pwm_valid_s = 1'b0;
                    gap_s       = GAP_LOAD;
                    state_s     = POST_XFER;
                end else begin
                    pwm_valid_s = 1'b1;
                end
            end

            S_GAP: begin
                pwm_valid_s = 1'b0;
                if (gap_r == '0) begin
                    state_s = S_IDLE;
                end else begin
                    gap_s = gap_r - GAP_W'(1);
                end
            end

            default: begin
                pwm_valid_s = 1'b0;
                state_s     = S_INIT;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_INIT;
            pwm_valid_r  <= 1'b0;
            pwm_data_r   <= NEUTRAL_CMD;
            active_src_r <= SRC_NONE;
            timeout_r    <= 1'b0;
            hold_r       <= '0;
            gap_r        <= '0;
            wdog_r       <= WDOG_LOAD;
        end else begin
            state_r      <= state_s;
            pwm_valid_r  <= pwm_valid_s;
            pwm_data_r   <= pwm_data_s;
            active_src_r <= active_src_s;
            timeout_r    <= timeout_s;
            hold_r       <= hold_s;
            gap_r        <= gap_s;
            wdog_r       <= wdog_s;
        end
    end

    // Accept strobes are combinational from state, valids and lockout; the rest is registered.
    assign man_rdy      = man_rdy_s;
    assign auto_rdy     = auto_rdy_s;
    assign pwm_data     = pwm_data_r;
    assign pwm_valid    = pwm_valid_r;
    assign active_src   = active_src_r;
    assign timeout_flag = timeout_r;

    pwm_cmd_sched_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .man_valid (man_valid),
        .man_rdy   (man_rdy),
        .auto_rdy  (auto_rdy),
        .pwm_data  (pwm_data),
        .pwm_valid (pwm_valid),
        .pwm_rdy   (pwm_rdy)
    );

endmodule

// File: tb/tb_pwm_cmd_sched.sv
// Testbench for pwm_cmd_sched: a directed cycle table for startup and
// arbitration, hand-written sequences for lockout, stall, watchdog and reset,
// then randomized traffic against a timestamp-based reference model.
module tb_pwm_cmd_sched;

    localparam logic [15:0] NEUTRAL = 16'h8000;
    localparam int T_HOLD = 2000;
    localparam int T_GAP  = 4;
    localparam int T_WDOG = 2500;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] man_cmd;
    logic        man_valid;
    logic        man_rdy;
    logic [15:0] auto_cmd;
    logic        auto_valid;
    logic        auto_rdy;
    logic [15:0] pwm_data;
    logic        pwm_valid;
    logic        pwm_rdy;
    logic [1:0]  active_src;
    logic        timeout_flag;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    pwm_cmd_sched #(
        .NEUTRAL_CMD (NEUTRAL),
        .MAN_HOLD    (T_HOLD),
        .MIN_GAP     (T_GAP),
        .WDOG_CYCLES (T_WDOG)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .man_cmd      (man_cmd),
        .man_valid    (man_valid),
        .man_rdy      (man_rdy),
        .auto_cmd     (auto_cmd),
        .auto_valid   (auto_valid),
        .auto_rdy     (auto_rdy),
        .pwm_data     (pwm_data),
        .pwm_valid    (pwm_valid),
        .pwm_rdy      (pwm_rdy),
        .active_src   (active_src),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mv;
        logic [15:0] mc;
        logic        av;
        logic [15:0] ac;
        logic        pr;
        logic        ev;
        logic [15:0] ed;
        logic [1:0]  es;
        logic        emr;
        logic        ear;
        logic        ef;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic mv, input logic [15:0] mc, input logic av,
                                input logic [15:0] ac, input logic pr, input logic ev,
                                input logic [15:0] ed, input logic [1:0] es,
                                input logic emr, input logic ear, input logic ef);
        vec_t v;
        v.mv = mv; v.mc = mc; v.av = av; v.ac = ac; v.pr = pr;
        v.ev = ev; v.ed = ed; v.es = es; v.emr = emr; v.ear = ear; v.ef = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Wait (bounded) for an auto accept; leaves time at the negedge of the accept cycle.
    task automatic wait_auto_accept(input int limit, output int at);
        at = -1;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (auto_valid && auto_rdy) begin
                at = cyc;
                break;
            end
            step();
        end
    endtask

    function automatic logic [31:0] pack(input logic v, input logic [15:0] d, input logic [1:0] s,
                                         input logic f, input logic mr, input logic ar);
        return {10'd0, v, d, s, f, mr, ar};
    endfunction

    // Reference model: timestamps instead of counters.
    bit          m_pre;
    bit          m_offer;
    logic [15:0] m_data;
    logic [1:0]  m_src;
    bit          m_flag;
    int          t_idle_from;
    int          t_man;
    int          t_ext;

    task automatic model_reset();
        m_pre = 1'b1; m_offer = 1'b0; m_data = NEUTRAL; m_src = 2'd0; m_flag = 1'b0;
        t_idle_from = 0; t_man = -T_HOLD; t_ext = 0;
    endtask

    initial begin
        int found;
        int acc;
        int vcount;
        int mode;
        bit man_acc;
        bit auto_acc;
        bit idle;
        bit hold_ok;
        bit wd_exp;
        logic [31:0] expv;

        tbl[0]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, NEUTRAL,  2'd0, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, NEUTRAL,  2'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 2; i < 6; i++)
            tbl[i] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, NEUTRAL, 2'd0, 1'b0, 1'b0, 1'b0);
        tbl[6]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, NEUTRAL,  2'd0, 1'b1, 1'b1, 1'b0);
        tbl[7]  = mk(1'b1, 16'h40C0, 1'b1, 16'hA010, 1'b1, 1'b0, NEUTRAL,  2'd0, 1'b1, 1'b0, 1'b0);
        tbl[8]  = mk(1'b0, 16'h0000, 1'b1, 16'hA010, 1'b0, 1'b1, 16'h40C0, 2'd1, 1'b0, 1'b0, 1'b0);
        tbl[9]  = mk(1'b0, 16'h0000, 1'b1, 16'hA010, 1'b0, 1'b1, 16'h40C0, 2'd1, 1'b0, 1'b0, 1'b0);
        tbl[10] = mk(1'b0, 16'h0000, 1'b1, 16'hA010, 1'b1, 1'b1, 16'h40C0, 2'd1, 1'b0, 1'b0, 1'b0);
        for (int i = 11; i < 15; i++)
            tbl[i] = mk(1'b0, 16'h0000, 1'b1, 16'hA010, 1'b1, 1'b0, 16'h40C0, 2'd1, 1'b0, 1'b0, 1'b0);
        tbl[15] = mk(1'b0, 16'h0000, 1'b1, 16'hA010, 1'b1, 1'b0, 16'h40C0, 2'd1, 1'b1, 1'b0, 1'b0);

        rst = 1'b1; man_cmd = 16'h0000; man_valid = 1'b0; auto_cmd = 16'h0000;
        auto_valid = 1'b0; pwm_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", pack(pwm_valid, pwm_data, active_src, timeout_flag, man_rdy, auto_rdy),
              pack(1'b0, NEUTRAL, 2'd0, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;

        // Startup neutral, gap, simultaneous requests, output stall, lockout start.
        for (int i = 0; i < 16; i++) begin
            man_valid = tbl[i].mv; man_cmd = tbl[i].mc;
            auto_valid = tbl[i].av; auto_cmd = tbl[i].ac; pwm_rdy = tbl[i].pr;
            @(negedge clk);
            check($sformatf("vec%0d", i), pack(pwm_valid, pwm_data, active_src, timeout_flag, man_rdy, auto_rdy),
                  pack(tbl[i].ev, tbl[i].ed, tbl[i].es, tbl[i].ef, tbl[i].emr, tbl[i].ear));
            step();
        end

        // Auto lockout after the manual accept at the end of cycle 7.
        wait_auto_accept(3000, found);
        check("lockout_release_cycle", 32'(found), 32'(7 + 1 + T_HOLD));
        check("lockout_man_rdy", 32'(man_rdy), 32'd1);
        step();
        auto_cmd = 16'h2222; auto_valid = 1'b1; pwm_rdy = 1'b0;
        @(negedge clk);
        check("auto_accept", pack(pwm_valid, pwm_data, active_src, timeout_flag, 1'b0, 1'b0),
              pack(1'b1, 16'hA010, 2'd2, 1'b0, 1'b0, 1'b0));

        // Output stalled for 50 cycles with a pending auto request.
        for (int k = 0; k < 50; k++) begin
            if (k > 0) @(negedge clk);
            check("stall", {13'd0, pwm_valid, pwm_data, man_rdy, auto_rdy}, {13'd0, 1'b1, 16'hA010, 2'b00});
            step();
        end
        pwm_rdy = 1'b1;
        wait_auto_accept(100, acc);
        check("gap_then_accept_cycle", 32'(acc), 32'(2009 + 50 + 1 + T_GAP));
        step();
        auto_valid = 1'b0;
        @(negedge clk);
        check("second_auto", pack(pwm_valid, pwm_data, active_src, timeout_flag, 1'b0, 1'b0),
              pack(1'b1, 16'h2222, 2'd2, 1'b0, 1'b0, 1'b0));

        // Watchdog: silence after the last accept leads to one neutral command.
        found = -1;
        while (found < 0 && cyc < acc + T_WDOG + 200) begin
            step();
            @(negedge clk);
            if (pwm_valid && active_src == 2'd3) found = cyc;
        end
        check("wdog_issue_cycle", 32'(found), 32'(acc + 2 + T_WDOG));
        check("wdog_issue", {13'd0, pwm_data, active_src, timeout_flag}, {13'd0, NEUTRAL, 2'd3, 1'b1});
        vcount = 0;
        for (int k = 0; k < 1000; k++) begin
            step();
            @(negedge clk);
            if (pwm_valid) vcount++;
        end
        check("wdog_no_repeat", 32'(vcount), 32'd0);
        check("wdog_flag_held", 32'(timeout_flag), 32'd1);
        step();
        auto_cmd = 16'h3333; auto_valid = 1'b1;
        wait_auto_accept(50, found);
        check("post_timeout_accept_seen", 32'(found >= 0), 32'd1);
        step();
        auto_valid = 1'b0;
        @(negedge clk);
        check("flag_cleared", pack(pwm_valid, pwm_data, active_src, timeout_flag, 1'b0, 1'b0),
              pack(1'b1, 16'h3333, 2'd2, 1'b0, 1'b0, 1'b0));

        // Reset while a command is on the output.
        rst = 1'b1;
        #1;
        check("midreset_drop", {13'd0, pwm_valid, pwm_data, active_src}, {13'd0, 1'b0, NEUTRAL, 2'd0});
        @(posedge clk);
        #1;
        rst = 1'b0; cyc = 0; pwm_rdy = 1'b1;
        @(negedge clk);
        check("restart_c0", 32'(pwm_valid), 32'd0);
        step();
        @(negedge clk);
        check("restart_neutral", pack(pwm_valid, pwm_data, active_src, timeout_flag, man_rdy, auto_rdy),
              pack(1'b1, NEUTRAL, 2'd0, 1'b0, 1'b0, 1'b0));

        // Randomized traffic against the reference model.
        rst = 1'b1; man_valid = 1'b0; auto_valid = 1'b0;
        step();
        step();
        rst = 1'b0; cyc = 0;
        model_reset();
        man_acc = 1'b0; auto_acc = 1'b0;
        for (int seg = 0; seg < 6; seg++) begin
            mode = (seg == 1 || seg == 4) ? 0 : int'($urandom_range(1, 2));
            for (int k = 0; k < 3000; k++) begin
                if (!man_valid || man_acc) begin
                    man_valid = (mode == 2) && ($urandom_range(0, 299) == 0);
                    man_cmd = 16'($urandom);
                end
                if (!auto_valid || auto_acc) begin
                    auto_valid = (mode != 0) && ($urandom_range(0, 24) == 0);
                    auto_cmd = 16'($urandom);
                end
                pwm_rdy = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                idle    = !m_pre && !m_offer && (cyc >= t_idle_from);
                hold_ok = (cyc - t_man) >= T_HOLD;
                wd_exp  = (cyc - t_ext) >= T_WDOG;
                expv = pack(m_offer, m_data, m_src, m_flag, idle, idle && !man_valid && hold_ok);
                check("random", pack(pwm_valid, pwm_data, active_src, timeout_flag, man_rdy, auto_rdy), expv);
                man_acc  = man_valid && man_rdy;
                auto_acc = auto_valid && auto_rdy;
                if (m_pre) begin
                    m_pre = 1'b0; m_offer = 1'b1;
                end else if (m_offer) begin
                    if (pwm_rdy) begin
                        m_offer = 1'b0;
                        t_idle_from = cyc + 1 + T_GAP;
                    end
                end else if (idle) begin
                    if (man_valid) begin
                        m_offer = 1'b1; m_data = man_cmd; m_src = 2'd1; m_flag = 1'b0;
                        t_man = cyc + 1; t_ext = cyc + 1;
                    end else if (auto_valid && hold_ok) begin
                        m_offer = 1'b1; m_data = auto_cmd; m_src = 2'd2; m_flag = 1'b0;
                        t_ext = cyc + 1;
                    end else if (wd_exp && !m_flag) begin
                        m_offer = 1'b1; m_data = NEUTRAL; m_src = 2'd3; m_flag = 1'b1;
                    end
                end
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
